// File: rtl/invalid_fill_stats_fp16.sv
// invalid_fill_stats_fp16
// Streaming stage after the depth threshold stage. Pixels marked with the
// fp16 pattern 16'h7FFF are invalid. Short runs of them are replaced with the
// last valid depth seen in the same row. The block also keeps per-frame
// total/invalid/filled pixel counts and publishes them once per frame.

module invalid_fill_stats_fp16 #(
    parameter int MAX_GAP = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [15:0]      data_i,
    input  logic [15:0]      confidence_i,
    input  logic [15:0]      col_i,
    input  logic [15:0]      row_i,
    input  logic             valid_i,
    input  logic [15:0]      frame_width_i,
    input  logic [15:0]      frame_height_i,
    output logic [15:0]      data_o,
    output logic [15:0]      confidence_o,
    output logic [15:0]      col_o,
    output logic [15:0]      row_o,
    output logic             valid_o,
    output logic             filled_o,
    output logic [CNT_W-1:0] total_count_o,
    output logic [CNT_W-1:0] invalid_count_o,
    output logic [CNT_W-1:0] filled_count_o,
    output logic             stats_valid_o
);

    // The gap counter must hold 0..MAX_GAP; keep at least one bit when
    // filling is disabled.
    localparam int               GAP_W   = (MAX_GAP < 1) ? 1 : $clog2(MAX_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_LIM = GAP_W'(MAX_GAP);
    localparam logic [15:0]      INVALID = 16'h7FFF;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Row history
    logic [15:0]      held_data;
    logic             held_ok;
    logic [GAP_W-1:0] gap;

    // Running counts for the frame in progress
    logic [CNT_W-1:0] run_total;
    logic [CNT_W-1:0] run_invalid;
    logic [CNT_W-1:0] run_filled;

    // Per-beat decisions
    logic             is_invalid;
    logic             eff_ok;
    logic [GAP_W-1:0] eff_gap;
    logic             do_fill;
    logic             frame_end;
    logic [CNT_W-1:0] total_next;
    logic [CNT_W-1:0] invalid_next;
    logic [CNT_W-1:0] filled_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
    endfunction

    // Classify the incoming beat and work out fill and count updates.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        eff_ok  = held_ok;
        eff_gap = gap;
        // Column 0 starts a new row: prior history must not leak across rows.
        if (col_i == 16'd0) begin
            eff_ok  = 1'b0;
            eff_gap = '0;
        end
        is_invalid   = (data_i == INVALID);
        do_fill      = is_invalid && eff_ok && (eff_gap < GAP_LIM);
        frame_end    = (col_i == frame_width_i - 16'd1) &&
                       (row_i == frame_height_i - 16'd1);
        total_next   = sat_inc(run_total, 1'b1);
        invalid_next = sat_inc(run_invalid, is_invalid);
        filled_next  = sat_inc(run_filled, do_fill);
    end

    // Data path: register the beat, substitute held depth when filling,
    // and update the row history.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst_i) begin
            data_o       <= '0;
            confidence_o <= '0;
            col_o        <= '0;
            row_o        <= '0;
            valid_o      <= 1'b0;
            filled_o     <= 1'b0;
            held_data    <= '0;
            held_ok      <= 1'b0;
            gap          <= '0;
        end else begin
            valid_o  <= valid_i;
            filled_o <= valid_i && do_fill;
            if (valid_i) begin
                confidence_o <= confidence_i;
                col_o        <= col_i;
                row_o        <= row_i;
                if (!is_invalid) begin
                    data_o    <= data_i;
                    held_data <= data_i;
                    held_ok   <= 1'b1;
                    gap       <= '0;
                end else if (do_fill) begin
                    data_o  <= held_data;
                    held_ok <= 1'b1;
                    gap     <= eff_gap + GAP_W'(1);
                end else begin
                    // Run too long or no valid pixel yet in this row: the gap
                    // stays saturated until the next valid pixel.
                    data_o  <= INVALID;
                    held_ok <= eff_ok;
                    gap     <= eff_gap;
                end
            end
        end
    end

    // Statistics: accumulate per beat, publish and restart at frame end.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            run_total       <= '0;
            run_invalid     <= '0;
            run_filled      <= '0;
            total_count_o   <= '0;
            invalid_count_o <= '0;
            filled_count_o  <= '0;
            stats_valid_o   <= 1'b0;
        end else begin
            stats_valid_o <= 1'b0;
            if (valid_i) begin
                if (frame_end) begin
                    total_count_o   <= total_next;
                    invalid_count_o <= invalid_next;
                    filled_count_o  <= filled_next;
                    stats_valid_o   <= 1'b1;
                    run_total       <= '0;
                    run_invalid     <= '0;
                    run_filled      <= '0;
                end else begin
                    run_total   <= total_next;
                    run_invalid <= invalid_next;
                    run_filled  <= filled_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_invalid_fill_stats_fp16.sv
// Testbench for invalid_fill_stats_fp16. Three instances share one stimulus
// stream: MAX_GAP=4, MAX_GAP=2, and MAX_GAP=0 with 3-bit counters (to reach
// counter saturation). A row-level model predicts every output each cycle;
// directed literal checks pin the model to hand-computed values.

module tb_invalid_fill_stats_fp16;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i;
    logic [15:0] data_i, confidence_i, col_i, row_i, frame_width_i, frame_height_i;
    logic        valid_i;

    logic [15:0] d_data [3];
    logic [15:0] d_conf [3];
    logic [15:0] d_col  [3];
    logic [15:0] d_row  [3];
    logic        d_valid[3];
    logic        d_filled[3];
    logic        d_sv   [3];
    logic [31:0] d_tot  [3];
    logic [31:0] d_inv  [3];
    logic [31:0] d_fil  [3];
    logic [2:0]  tot_s, inv_s, fil_s;

    assign d_tot[2] = {29'd0, tot_s};
    assign d_inv[2] = {29'd0, inv_s};
    assign d_fil[2] = {29'd0, fil_s};

    invalid_fill_stats_fp16 #(.MAX_GAP(4), .CNT_W(32)) dut_g4 (
        .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .confidence_i(confidence_i),
        .col_i(col_i), .row_i(row_i), .valid_i(valid_i),
        .frame_width_i(frame_width_i), .frame_height_i(frame_height_i),
        .data_o(d_data[0]), .confidence_o(d_conf[0]), .col_o(d_col[0]), .row_o(d_row[0]),
        .valid_o(d_valid[0]), .filled_o(d_filled[0]),
        .total_count_o(d_tot[0]), .invalid_count_o(d_inv[0]), .filled_count_o(d_fil[0]),
        .stats_valid_o(d_sv[0]));

    invalid_fill_stats_fp16 #(.MAX_GAP(2), .CNT_W(32)) dut_g2 (
        .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .confidence_i(confidence_i),
        .col_i(col_i), .row_i(row_i), .valid_i(valid_i),
        .frame_width_i(frame_width_i), .frame_height_i(frame_height_i),
        .data_o(d_data[1]), .confidence_o(d_conf[1]), .col_o(d_col[1]), .row_o(d_row[1]),
        .valid_o(d_valid[1]), .filled_o(d_filled[1]),
        .total_count_o(d_tot[1]), .invalid_count_o(d_inv[1]), .filled_count_o(d_fil[1]),
        .stats_valid_o(d_sv[1]));

    invalid_fill_stats_fp16 #(.MAX_GAP(0), .CNT_W(3)) dut_g0 (
        .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .confidence_i(confidence_i),
        .col_i(col_i), .row_i(row_i), .valid_i(valid_i),
        .frame_width_i(frame_width_i), .frame_height_i(frame_height_i),
        .data_o(d_data[2]), .confidence_o(d_conf[2]), .col_o(d_col[2]), .row_o(d_row[2]),
        .valid_o(d_valid[2]), .filled_o(d_filled[2]),
        .total_count_o(tot_s), .invalid_count_o(inv_s), .filled_count_o(fil_s),
        .stats_valid_o(d_sv[2]));

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [15:0] data, conf, col, row;
        logic        valid, filled, sv;
        longint      tot, inv, fil;
    } out_t;

    int     gaps[3] = '{4, 2, 0};
    longint cmax[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd7};

    out_t        exp_cur[3];
    out_t        exp_nxt[3];
    bit          has_valid[3];
    logic [15:0] last_d[3];
    int          run_len[3];
    longint      r_tot[3], r_inv[3], r_fil[3];

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    function automatic longint sat1(longint v, longint mx);
        return (v + 1 > mx) ? mx : v + 1;
    endfunction

    task automatic model_reset(int k);
        has_valid[k] = 1'b0;
        run_len[k]   = 0;
        last_d[k]    = 16'h0;
        r_tot[k] = 0; r_inv[k] = 0; r_fil[k] = 0;
        exp_nxt[k] = '{data: 16'h0, conf: 16'h0, col: 16'h0, row: 16'h0,
                       valid: 1'b0, filled: 1'b0, sv: 1'b0, tot: 0, inv: 0, fil: 0};
    endtask

    // Fill rule stated per row: an invalid pixel takes the last valid depth of
    // its row if fewer than MAX_GAP invalid pixels have followed that depth.
    task automatic model_beat(int k);
        bit inv;
        inv = (data_i == 16'h7FFF);
        if (col_i == 16'd0) begin
            has_valid[k] = 1'b0;
            run_len[k]   = 0;
        end
        exp_nxt[k].valid = 1'b1;
        exp_nxt[k].conf  = confidence_i;
        exp_nxt[k].col   = col_i;
        exp_nxt[k].row   = row_i;
        if (!inv) begin
            exp_nxt[k].data   = data_i;
            exp_nxt[k].filled = 1'b0;
            has_valid[k] = 1'b1;
            last_d[k]    = data_i;
            run_len[k]   = 0;
        end else if (has_valid[k] && run_len[k] < gaps[k]) begin
            exp_nxt[k].data   = last_d[k];
            exp_nxt[k].filled = 1'b1;
            run_len[k]++;
        end else begin
            exp_nxt[k].data   = 16'h7FFF;
            exp_nxt[k].filled = 1'b0;
        end
        r_tot[k] = sat1(r_tot[k], cmax[k]);
        if (inv) r_inv[k] = sat1(r_inv[k], cmax[k]);
        if (exp_nxt[k].filled) r_fil[k] = sat1(r_fil[k], cmax[k]);
        if (col_i == frame_width_i - 16'd1 && row_i == frame_height_i - 16'd1) begin
            exp_nxt[k].tot = r_tot[k];
            exp_nxt[k].inv = r_inv[k];
            exp_nxt[k].fil = r_fil[k];
            exp_nxt[k].sv  = 1'b1;
            r_tot[k] = 0; r_inv[k] = 0; r_fil[k] = 0;
        end else begin
            exp_nxt[k].sv = 1'b0;
        end
    endtask

    task automatic model_idle(int k);
        exp_nxt[k].valid  = 1'b0;
        exp_nxt[k].filled = 1'b0;
        exp_nxt[k].sv     = 1'b0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic r, input logic v, input logic [15:0] row,
                        input logic [15:0] col, input logic [15:0] data);
        rst_i        = r;
        valid_i      = v;
        row_i        = row;
        col_i        = col;
        data_i       = data;
        confidence_i = data ^ {row[7:0], col[7:0]} ^ 16'h5A5A;
        for (int k = 0; k < 3; k++) begin
            if (r)      model_reset(k);
            else if (v) model_beat(k);
            else        model_idle(k);
        end
        @(posedge clk);
        #1;
        exp_cur = exp_nxt;
    endtask

    task automatic beat(input logic [15:0] row, input logic [15:0] col, input logic [15:0] data);
        step(1'b0, 1'b1, row, col, data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'd0, 16'd0, 16'd0);
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 3; k++) begin
                logic [162:0] act, exp;
                act = {d_data[k], d_conf[k], d_col[k], d_row[k], d_valid[k], d_filled[k],
                       d_sv[k], d_tot[k], d_inv[k], d_fil[k]};
                exp = {exp_cur[k].data, exp_cur[k].conf, exp_cur[k].col, exp_cur[k].row,
                       exp_cur[k].valid, exp_cur[k].filled, exp_cur[k].sv,
                       exp_cur[k].tot[31:0], exp_cur[k].inv[31:0], exp_cur[k].fil[31:0]};
                n_cmp++;
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL model_cmp dut%0d: got %h expected %h (t=%0t)", k, act, exp, $time);
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    logic [15:0] a_in [6] = '{16'h3C00, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h4200};
    logic [15:0] a_e2 [6] = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h7FFF, 16'h7FFF, 16'h4200};
    logic        a_f2 [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [15:0] b_in [5] = '{16'h3C00, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h4000};
    logic [15:0] b_e4 [5] = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h4000};
    logic        b_f4 [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] f_in [8] = '{16'h3C00, 16'h7FFF, 16'h7FFF, 16'h3C00,
                              16'h7FFF, 16'h4000, 16'h4000, 16'h4000};

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; data_i = '0; confidence_i = '0;
        col_i = '0; row_i = '0;
        frame_width_i = 16'd8; frame_height_i = 16'd2;

        do_reset(2);
        cmp_en = 1'b1;
        chk("reset.valid", d_valid[0], 0);
        chk("reset.data", d_data[0], 0);
        chk("reset.total", d_tot[0], 0);
        chk("reset.stats_valid", d_sv[0], 0);

        // Long run in row 0 (MAX_GAP=2 check), short run in row 1 (MAX_GAP=4 check)
        for (int i = 0; i < 6; i++) begin
            beat(16'd0, 16'(i), a_in[i]);
            chk("gap2.data", d_data[1], a_e2[i]);
            chk("gap2.filled", d_filled[1], a_f2[i]);
        end
        for (int i = 0; i < 5; i++) begin
            beat(16'd1, 16'(i), b_in[i]);
            chk("gap4.data", d_data[0], b_e4[i]);
            chk("gap4.filled", d_filled[0], b_f4[i]);
        end
        idle(2);
        chk("no_frame_end.total", d_tot[0], 0);

        // 4x2 frame with idle gaps; row 1 col 0 is invalid after a valid row end
        do_reset(1);
        frame_width_i = 16'd4;
        for (int i = 0; i < 8; i++) begin
            beat(16'(i / 4), 16'(i % 4), f_in[i]);
            if (i == 4) begin
                chk("row_boundary.data", d_data[0], 16'h7FFF);
                chk("row_boundary.filled", d_filled[0], 0);
            end
            if (i < 7) idle(1 + (i % 2));
        end
        chk("frame.stats_valid", d_sv[0], 1);
        chk("frame.total", d_tot[0], 8);
        chk("frame.invalid", d_inv[0], 3);
        chk("frame.filled", d_fil[0], 2);
        chk("frame.gap2_filled", d_fil[1], 2);
        chk("frame.sat_total", d_tot[2], 7);
        chk("frame.gap0_filled", d_fil[2], 0);
        idle(1);
        chk("frame.pulse_end", d_sv[0], 0);
        chk("frame.hold_total", d_tot[0], 8);

        // Next frame counts from zero: one invalid, fillable
        for (int i = 0; i < 8; i++) beat(16'(i / 4), 16'(i % 4), (i == 2) ? 16'h7FFF : 16'h4400);
        chk("frame2.total", d_tot[0], 8);
        chk("frame2.invalid", d_inv[0], 1);
        chk("frame2.filled", d_fil[0], 1);

        // Reset after 5 beats, with a beat presented during reset
        for (int i = 0; i < 5; i++) beat(16'(i / 4), 16'(i % 4), 16'h3C00);
        step(1'b1, 1'b1, 16'd1, 16'd1, 16'h3C00);
        chk("mid_reset.valid", d_valid[0], 0);
        step(1'b1, 1'b0, 16'd0, 16'd0, 16'd0);
        chk("mid_reset.valid2", d_valid[0], 0);
        for (int i = 0; i < 8; i++) beat(16'(i / 4), 16'(i % 4), (i == 5) ? 16'h7FFF : 16'h3C00);
        chk("after_reset.total", d_tot[0], 8);
        chk("after_reset.invalid", d_inv[0], 1);
        chk("after_reset.filled", d_fil[0], 1);

        // Alternating valid/invalid: MAX_GAP=0 never fills
        for (int i = 0; i < 8; i++) begin
            beat(16'(i / 4), 16'(i % 4), (i % 2 == 1) ? 16'h7FFF : 16'h3C00);
            chk("alt.gap0_filled_o", d_filled[2], 0);
        end
        chk("alt.gap0_invalid", d_inv[2], 4);
        chk("alt.gap0_filled", d_fil[2], 0);
        chk("alt.gap4_filled", d_fil[0], 4);
        idle(2);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
